// File: rtl/bec_key_sequencer_pkg.sv
// Shared definitions for the BEC key sequencer: FSM state encoding and scalar width.
package bec_key_sequencer_pkg;

    localparam int unsigned BEC_KEY_BITS = 163;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOADED = 2'b01,
        ST_RUN    = 2'b11,
        ST_FINISH = 2'b10
    } state_t;

endpackage

// File: rtl/bec_key_sequencer_if.sv
// Handshake between the key sequencer (master) and the sm_bec_v3 ladder core (slave).
interface bec_key_sequencer_if;

    logic core_enable;
    logic core_ki;
    logic core_next_key;
    logic core_done;

    modport master (
        output core_enable,
        output core_ki,
        input  core_next_key,
        input  core_done
    );

    modport slave (
        input  core_enable,
        input  core_ki,
        output core_next_key,
        output core_done
    );

endinterface

// File: rtl/bec_key_sequencer_watchdog.sv
// Per-bit watchdog: counts ticks since the last clear and pulses expired on the TIMEOUT-th tick.
module bec_watchdog #(
    parameter int unsigned TIMEOUT = 2000,
    parameter int unsigned TMR_W   = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        expired = tick && !clear && (cnt_q == TMR_W'(TIMEOUT - 1));
        cnt_d   = cnt_q;
        if (clear || expired) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bec_key_sequencer.sv
// Steps the BEC Montgomery-ladder core through the scalar, one ki bit per core_next_key,
// with a per-bit watchdog and sticky timeout/overrun error flags.
module bec_key_sequencer
    import bec_key_sequencer_pkg::*;
#(
    parameter int unsigned KEY_BITS = BEC_KEY_BITS,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned TIMEOUT  = 2000,
    parameter int unsigned TMR_W    = 11
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                key_load,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                start,
    input  logic                abort,
    bec_key_sequencer_if.master core,
    output logic                res_capture,
    output logic                busy,
    output logic                done,
    output logic                err_timeout,
    output logic                err_overrun,
    output logic [CNT_W-1:0]    bits_done
);

    state_t              state_q, state_d;
    logic [KEY_BITS-1:0] key_sr_q, key_sr_d;
    logic [CNT_W-1:0]    bits_done_q, bits_done_d;
    logic                err_timeout_q, err_timeout_d;
    logic                err_overrun_q, err_overrun_d;
    logic                in_run;
    logic                wd_clear;
    logic                wd_expired;

    assign in_run   = (state_q == ST_RUN);
    assign wd_clear = !in_run || core.core_next_key;

    bec_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_wdog (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (wd_clear),
        .tick    (in_run),
        .expired (wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        key_sr_d      = key_sr_q;
        bits_done_d   = bits_done_q;
        err_timeout_d = err_timeout_q;
        err_overrun_d = err_overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (key_load) begin
                    key_sr_d      = key_in;
                    err_timeout_d = 1'b0;
                    err_overrun_d = 1'b0;
                    state_d       = ST_LOADED;
                end
            end
            ST_LOADED: begin
                if (key_load) begin
                    key_sr_d      = key_in;
                    err_timeout_d = 1'b0;
                    err_overrun_d = 1'b0;
                end
                if (start) begin
                    bits_done_d   = '0;
                    err_timeout_d = 1'b0;
                    err_overrun_d = 1'b0;
                    state_d       = ST_RUN;
                end
            end
            ST_RUN: begin
                // abort wins over everything, including a same-cycle next_key
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (wd_expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    if (core.core_next_key) begin
                        key_sr_d = key_sr_q >> 1;
                        if (bits_done_q == CNT_W'(KEY_BITS)) begin
                            err_overrun_d = 1'b1;
                        end else begin
                            bits_done_d = bits_done_q + CNT_W'(1);
                        end
                    end
                    if (core.core_done) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q       <= ST_IDLE;
            key_sr_q      <= '0;
            bits_done_q   <= '0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_sr_q      <= key_sr_d;
            bits_done_q   <= bits_done_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign core.core_enable = in_run;
    assign core.core_ki     = in_run && key_sr_q[0];
    assign busy             = in_run;
    assign done             = (state_q == ST_FINISH);
    assign res_capture      = (state_q == ST_FINISH);
    assign err_timeout      = err_timeout_q;
    assign err_overrun      = err_overrun_q;
    assign bits_done        = bits_done_q;

endmodule

// File: tb/tb_bec_key_sequencer.sv
// Self-checking bench for bec_key_sequencer: cycle table, directed corner cases, randomized runs.
module tb_bec_key_sequencer;

    localparam int unsigned KB = 163;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_load;
    logic [KB-1:0] key_in;
    logic          start;
    logic          abort;
    logic          res_capture;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic          err_overrun;
    logic [7:0]    bits_done;

    int n_vec = 0;
    int n_err = 0;

    bec_key_sequencer_if core_if ();

    bec_key_sequencer #(
        .KEY_BITS (KB),
        .CNT_W    (8),
        .TIMEOUT  (2000),
        .TMR_W    (11)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .key_load    (key_load),
        .key_in      (key_in),
        .start       (start),
        .abort       (abort),
        .core        (core_if),
        .res_capture (res_capture),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .bits_done   (bits_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       kl;
        logic       st;
        logic       ab;
        logic       nk;
        logic       cd;
        logic [7:0] kin;
        logic [14:0] exp;
    } vec_t;

    // Packed view: {busy, enable, ki, done, res_capture, err_timeout, err_overrun, bits_done}
    function automatic logic [14:0] outs();
        return {busy, core_if.core_enable, core_if.core_ki, done, res_capture,
                err_timeout, err_overrun, bits_done};
    endfunction

    function automatic logic [14:0] mk(input logic b, input logic e, input logic k,
                                       input logic d, input logic r, input logic to,
                                       input logic ov, input logic [7:0] bits);
        return {b, e, k, d, r, to, ov, bits};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        key_load = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        core_if.core_next_key = 1'b0;
        core_if.core_done     = 1'b0;
    endtask

    // One complete run judged from the scalar rules: bit i of the key is presented before the
    // i-th next_key (zero past the key width), the count saturates at KB, extra pulses flag overrun.
    task automatic do_run(input logic [KB-1:0] key, input int n, input int gmin, input int gmax,
                          input bit do_abort, input string tag);
        int   exp_bits;
        logic exp_ki;
        logic [14:0] e;
        exp_bits = (n > int'(KB)) ? int'(KB) : n;
        key_in = key; key_load = 1'b1; step(); key_load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk({tag, "_start_en"}, 32'(core_if.core_enable), 32'd1);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gmax, gmin)) step();
            exp_ki = (i < int'(KB)) ? key[i] : 1'b0;
            chk($sformatf("%s_ki%0d", tag, i), 32'(core_if.core_ki), 32'(exp_ki));
            core_if.core_next_key = 1'b1; step(); core_if.core_next_key = 1'b0;
        end
        abort = do_abort; core_if.core_done = 1'b1; step();
        abort = 1'b0;     core_if.core_done = 1'b0;
        e = mk(1'b0, 1'b0, 1'b0, !do_abort, !do_abort, 1'b0, n > int'(KB), 8'(exp_bits));
        chk({tag, "_end"}, 32'(outs()), 32'(e));
        step();
        e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, n > int'(KB), 8'(exp_bits));
        chk({tag, "_after"}, 32'(outs()), 32'(e));
    endtask

    vec_t tbl[14];

    initial begin
        logic [KB-1:0] k;
        int bad;
        int n;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, mk(0, 0, 0, 0, 0, 0, 0, 8'd0)};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, mk(1, 1, 1, 0, 0, 0, 0, 8'd0)};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, mk(1, 1, 0, 0, 0, 0, 0, 8'd1)};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, mk(1, 1, 0, 0, 0, 0, 0, 8'd1)};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, mk(1, 1, 1, 0, 0, 0, 0, 8'd2)};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, mk(1, 1, 1, 0, 0, 0, 0, 8'd2)};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, mk(0, 0, 0, 1, 1, 0, 0, 8'd3)};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, mk(0, 0, 0, 0, 0, 0, 0, 8'd3)};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, mk(0, 0, 0, 0, 0, 0, 0, 8'd3)};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, mk(0, 0, 0, 0, 0, 0, 0, 8'd3)};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, mk(1, 1, 0, 0, 0, 0, 0, 8'd0)};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, mk(0, 0, 0, 0, 0, 0, 0, 8'd0)};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, mk(0, 0, 0, 0, 0, 0, 0, 8'd0)};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, mk(0, 0, 0, 0, 0, 0, 0, 8'd0)};

        idle_inputs();
        key_in = '0;
        rst = 1'b1;
        step(); step();
        chk("reset_state", 32'(outs()), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            key_load = tbl[i].kl;
            start    = tbl[i].st;
            abort    = tbl[i].ab;
            core_if.core_next_key = tbl[i].nk;
            core_if.core_done     = tbl[i].cd;
            key_in   = KB'(tbl[i].kin);
            step();
            idle_inputs();
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        do_run(KB'(5), 163, 3, 3, 1'b0, "t1");
        do_run({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 40, 0, 2, 1'b1, "t3");
        do_run({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 164, 0, 1, 1'b0, "t4");

        // Watchdog expiry: enable held for exactly 2000 silent RUN cycles
        key_in = KB'(7); key_load = 1'b1; step(); key_load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        bad = 0;
        for (int c = 0; c < 2000; c++) begin
            if (core_if.core_enable !== 1'b1 || err_timeout !== 1'b0) bad++;
            step();
        end
        chk("t2_run_window", 32'(bad), 32'd0);
        chk("t2_expired", 32'(outs()), 32'(mk(0, 0, 0, 0, 0, 1, 0, 8'd0)));
        step();
        chk("t2_no_done", 32'(outs()), 32'(mk(0, 0, 0, 0, 0, 1, 0, 8'd0)));
        start = 1'b1; step(); start = 1'b0;
        chk("t2_start_ignored", 32'(outs()), 32'(mk(0, 0, 0, 0, 0, 1, 0, 8'd0)));
        key_load = 1'b1; step(); key_load = 1'b0;
        chk("t2_clear_on_load", 32'(outs()), 32'd0);

        // A next_key on the last allowed cycle keeps the run alive
        start = 1'b1; step(); start = 1'b0;
        repeat (1999) step();
        core_if.core_next_key = 1'b1; step(); core_if.core_next_key = 1'b0;
        chk("t2_rescue", 32'(outs()), 32'(mk(1, 1, 1, 0, 0, 0, 0, 8'd1)));
        abort = 1'b1; step(); abort = 1'b0;
        chk("t2_rescue_abort", 32'(outs()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 8'd1)));

        // Reset in the middle of a run
        key_in = ~KB'(0); key_load = 1'b1; step(); key_load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            core_if.core_next_key = 1'b1; step(); core_if.core_next_key = 1'b0;
        end
        chk("t5_bits80", 32'(bits_done), 32'd80);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t5_reset", 32'(outs()), 32'd0);
        start = 1'b1; step(); start = 1'b0;
        chk("t5_start_ignored", 32'(outs()), 32'd0);
        key_load = 1'b1; step(); key_load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("t5_restart", 32'(outs()), 32'(mk(1, 1, 1, 0, 0, 0, 0, 8'd0)));
        abort = 1'b1; step(); abort = 1'b0;

        for (int r = 0; r < 12; r++) begin
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(3, 0))
                0:       n = 163;
                1:       n = 164 + int'($urandom_range(2, 0));
                default: n = int'($urandom_range(162, 0));
            endcase
            do_run(k, n, 0, 4, ($urandom_range(3, 0) == 0), $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
